// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-mode, multi-slave SPI master.
// Holds the FSM state encoding, SPI mode constants and the length clamp.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_TRANSFER = 3'd2,
        ST_HOLD     = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Zero or over-long requests fall back to a full-width transfer
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: flags the last cycle of every H = div+1 cycle period.
// Loading restarts the period and latches the divider for the whole transfer.
module spi_half_tick #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_c_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            div_q <= div_i;
            cnt_q <= '0;
        end else if (cnt_q == div_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

    assign tick_c_o = (cnt_q == div_q);

endmodule

// File: rtl/spi_master_mc.sv
// Multi-mode SPI master with runtime mode, divider, length and chip select.
// Every phase (setup, each sck half-period, hold, gap) lasts H clk cycles.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_CS       = 4,
    parameter int unsigned CS_IDX_WIDTH = 2,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned LEN_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CS_IDX_WIDTH-1:0] cs_sel,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic [DIV_WIDTH-1:0]    clk_div,
    input  logic [LEN_WIDTH-1:0]    xfer_len,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    miso,
    output logic                    mosi,
    output logic                    sck,
    output logic [NUM_CS-1:0]       cs_n,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    busy,
    output logic                    new_data
);

    localparam int unsigned HP_W = LEN_WIDTH + 1;

    state_e                  state_q;
    logic [1:0]              mode_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [HP_W-1:0]         hp_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [DATA_WIDTH-1:0]   rx_q;
    logic                    sck_q;
    logic                    mosi_q;
    logic [NUM_CS-1:0]       cs_n_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    busy_q;
    logic                    new_data_q;

    logic                    accept_c;
    logic                    tick_c;
    logic                    cpol_c;
    logic                    drive_lead_c;
    logic [HP_W-1:0]         hp_nx_c;
    logic [HP_W-1:0]         last_idx_c;
    logic                    last_hp_c;
    logic                    nx_last_c;
    logic [DATA_WIDTH-1:0]   tx_shift_c;
    logic [DATA_WIDTH-1:0]   rx_shift_c;
    logic [NUM_CS-1:0]       cs_dec_c;

    assign accept_c     = (state_q == ST_IDLE) && start;
    assign cpol_c       = mode_q[1];
    assign drive_lead_c = (mode_q == SPI_MODE1) || (mode_q == SPI_MODE3);
    assign hp_nx_c      = hp_q + HP_W'(1);
    assign last_idx_c   = {len_q, 1'b0} - HP_W'(1);
    assign last_hp_c    = (hp_q == last_idx_c);
    assign nx_last_c    = (hp_nx_c == last_idx_c);
    assign tx_shift_c   = tx_q << 1;
    assign rx_shift_c   = {rx_q[DATA_WIDTH-2:0], miso};

    // Out-of-range indices select nothing, leaving every cs_n high
    always_comb begin
        cs_dec_c = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_IDX_WIDTH'(i)) begin
                cs_dec_c[i] = 1'b0;
            end
        end
    end

    spi_half_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_half_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept_c),
        .div_i    (clk_div),
        .tick_c_o (tick_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= SPI_MODE0;
            len_q      <= '0;
            hp_q       <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            new_data_q <= 1'b0;
        end else begin
            new_data_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETUP;
                        mode_q  <= {cpol, cpha};
                        len_q   <= LEN_WIDTH'(clamp_len(32'(xfer_len), DATA_WIDTH));
                        hp_q    <= '0;
                        tx_q    <= data_in;
                        rx_q    <= '0;
                        sck_q   <= cpol;
                        mosi_q  <= data_in[DATA_WIDTH-1];
                        cs_n_q  <= cs_dec_c;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    // Entering half-period 0 is the first leading edge
                    if (tick_c) begin
                        state_q <= ST_TRANSFER;
                        hp_q    <= '0;
                        sck_q   <= ~cpol_c;
                        if (!drive_lead_c) begin
                            rx_q <= rx_shift_c;
                        end
                    end
                end
                ST_TRANSFER: begin
                    if (tick_c) begin
                        if (last_hp_c) begin
                            state_q <= ST_HOLD;
                            sck_q   <= cpol_c;
                        end else begin
                            hp_q  <= hp_nx_c;
                            sck_q <= cpol_c ^ ~hp_nx_c[0];
                            if (hp_nx_c[0] == drive_lead_c) begin
                                // Sample edge: leading for CPHA=0, trailing for CPHA=1
                                rx_q <= rx_shift_c;
                            end else if (!nx_last_c) begin
                                tx_q   <= tx_shift_c;
                                mosi_q <= tx_shift_c[DATA_WIDTH-1];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_c) begin
                        state_q    <= ST_GAP;
                        cs_n_q     <= '1;
                        mosi_q     <= 1'b0;
                        data_out_q <= rx_q;
                        new_data_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick_c) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= '1;
                end
            endcase
        end
    end

    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign new_data = new_data_q;

endmodule
